run_sequencer: RTL

Top-level run controller for the 9-bit single-cycle processor core. Performs the testbench start/ack handshake, holds the program counter and gates instruction issue until a run begins, and counts run cycles. It raises ack on the decoded done instruction or on a watchdog timeout, and replaces the ad-hoc ever_start/start_off/overflow flops in the processor top.

---
 rtl/run_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: start/ack handshake, issue gating, cycle watchdog.
// Optional RUN_STATS_EN adds nop_in and a retired-instruction counter.
module run_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             done_in,
`ifdef RUN_STATS_EN
    input  logic             nop_in,
`endif
    output logic             run_en,
    output logic             pc_hold,
    output logic             ack,
    output logic             timed_out,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        DONE,
        TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = ARMED;
            end
            ARMED: begin
                if (!start) next_state = RUN;
            end
            RUN: begin
                if (done_in)                         next_state = DONE;
                else if (cycle_count == LAST_CYCLE)  next_state = TIMEOUT;
                else if (start)                      next_state = ARMED;
            end
            DONE, TIMEOUT: begin
                if (start) next_state = ARMED;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        run_en    = (state == RUN);
        pc_hold   = (state != RUN);
        ack       = (state == DONE) || (state == TIMEOUT);
        timed_out = (state == TIMEOUT);
        busy      = (state == ARMED) || (state == RUN);
    end

    // Counter advances only while staying in RUN, so it freezes on the final RUN cycle's value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (next_state == ARMED) begin
            cycle_count <= '0;
        end else if ((state == RUN) && (next_state == RUN)) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

`ifdef RUN_STATS_EN
    // Every non-NOP RUN cycle retires, including the one carrying the done instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
        end else if (next_state == ARMED) begin
            retired_count <= '0;
        end else if ((state == RUN) && !nop_in) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end
`else
    assign retired_count = '0;
`endif

endmodule
